// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential reads to a 1-cycle synchronous
// instruction RAM, queues returned words with their PCs, and serves them via valid/ready.
module fetch_queue #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       ram_rd_en,
  output logic [ADDR_W-1:0]          ram_addr1,
  input  logic [DATA_W-1:0]          ram_data1,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr_out,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH)+1-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              rd_pending_q, rd_pending_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              squash_q, squash_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic issue_s;
  logic push_s;
  logic pop_s;

  // Slot accounting counts the in-flight read so a returning word always has room.
  always_comb begin
    issue_s = rst_n & ~redirect &
              (({1'b0, count_q} + (CW+1)'(rd_pending_q)) < (CW+1)'(DEPTH));
    push_s  = rd_pending_q & ~squash_q & ~redirect;
    pop_s   = (count_q != {CW{1'b0}}) & instr_ready & ~redirect;
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rd_pending_d = rd_pending_q;
    pend_pc_d    = pend_pc_q;
    squash_d     = squash_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (redirect) begin
      // Flush wins over any same-cycle return or pop.
      fetch_pc_d   = redirect_pc;
      rd_pending_d = 1'b0;
      squash_d     = rd_pending_q;
      wr_ptr_d     = {PW{1'b0}};
      rd_ptr_d     = {PW{1'b0}};
      count_d      = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        fetch_pc_d   = fetch_pc_q + ADDR_W'(1);
        rd_pending_d = 1'b1;
        pend_pc_d    = fetch_pc_q;
        squash_d     = 1'b0;
      end else begin
        rd_pending_d = 1'b0;
        pend_pc_d    = pend_pc_q;
      end
      if (push_s) begin
        mem_d[wr_ptr_q] = {ram_data1, pend_pc_q};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d        = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q   <= ADDR_W'(RESET_PC);
      rd_pending_q <= 1'b0;
      pend_pc_q    <= {ADDR_W{1'b0}};
      squash_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      rd_pending_q <= rd_pending_d;
      pend_pc_q    <= pend_pc_d;
      squash_q     <= squash_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign ram_rd_en   = issue_s;
  assign ram_addr1   = fetch_pc_q;
  assign instr_valid = (count_q != {CW{1'b0}});
  assign instr_out   = mem_q[rd_ptr_q][ADDR_W +: DATA_W];
  assign instr_pc    = mem_q[rd_ptr_q][ADDR_W-1:0];
  assign occupancy   = count_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the multicycle ARM core.
- Generates the fetch PC and issues reads on the instruction RAM read port (1-cycle synchronous latency).
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to the controller/instruction-register stage through a valid/ready handshake.
- Supports branch redirect with flush, and squashes a stale in-flight read. Replaces single-word fetch into the instruction register.

Parameters:
- ADDR_W, 11: word-address width of instruction RAM and of all PCs.
- DATA_W, 32: instruction width.
- DEPTH, 4: FIFO entries, must be ≥2 and a power of 2.
- RESET_PC, 0: first word address fetched after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ram_rd_en  out  1  read request to instruction RAM this cycle.
- ram_addr1  out  ADDR_W  word address of the read request.
- ram_data1  in  DATA_W  read data, valid exactly one cycle after a ram_rd_en cycle.
- redirect  in  1  branch taken: discard queued/in-flight words, refetch from redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1.
- instr_valid  out  1  head entry valid.
- instr_out  out  DATA_W  head instruction.
- instr_pc  out  ADDR_W  word address of head instruction.
- instr_ready  in  1  consumer accepts head this cycle.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count, for debug/perf.

Behaviour:
- Reset (rst_n=0 at edge): fetch_pc←RESET_PC, FIFO empty (rd/wr pointers 0, count 0), rd_pending←0. While rst_n=0, ram_rd_en=0. instr_valid=0, occupancy=0, instr_out/instr_pc=0 after reset. Reset mid-operation discards everything, including in-flight data.
- State: fetch_pc, rd_pending (1 bit, read issued last cycle), pend_pc, squash (1 bit), FIFO storage {DATA_W+ADDR_W}×DEPTH, wr_ptr, rd_ptr, count.
- Issue rule (combinational): ram_rd_en = rst_n & ~redirect & (count + rd_pending < DEPTH); ram_addr1 = fetch_pc. Uses registered count only; a same-cycle pop does not open a slot until the next cycle. Overflow is therefore impossible.
- On issue: fetch_pc←fetch_pc+1 (wraps 2^ADDR_W−1→0), rd_pending←1, pend_pc←fetch_pc, squash←0. Otherwise rd_pending←0.
- Return: if rd_pending=1 and squash=0, push {ram_data1, pend_pc} at wr_ptr. If squash=1, discard.
- Pop: instr_valid&instr_ready advances rd_ptr. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- instr_valid = (count≠0); instr_out/instr_pc driven from FIFO head, registered storage. No bypass: a word returned at cycle t is visible at t+1 earliest. Fetch-to-valid latency is 2 cycles.
- Redirect (highest priority): at the edge with redirect=1, FIFO flushes (count←0, pointers←0) and fetch_pc←redirect_pc. If a read is in flight (rd_pending=1 next cycle from a prior issue), squash←1 so its return is dropped. No issue occurs in the redirect cycle. The first read of redirect_pc issues the following cycle.
- Redirect with instr_ready=1 in the same cycle: the head is considered consumed by the controller; the flush still clears everything.
- Back-to-back redirects: the last one wins; no words from earlier targets are ever presented.
- instr_ready while instr_valid=0: ignored.
- Steady state with instr_ready held 1: one instruction per cycle after the initial 2-cycle latency.

Test Plan:
- Reset, DEPTH=4, RESET_PC=0, instr_ready=0 → ram_rd_en high for 4 consecutive cycles at addresses 0,1,2,3, then low. occupancy reaches 4. instr_valid=1 with instr_pc=0 two cycles after first issue.
- Full FIFO, then instr_ready=1 for 1 cycle → head pc 0 popped, instr_pc=1 next. Address 4 issued the cycle after the pop, never before.
- Continuous instr_ready=1, RAM returns data = address×16 → instr_out sequence 0x00,0x10,0x20,… with instr_pc 0,1,2,…, one per cycle, no gaps.
- redirect=1, redirect_pc=0x100, while 3 entries queued and a read of 0x5 in flight → next cycle instr_valid=0 and 0x5 data never presented. Issue at 0x100 the cycle after. First valid instr_pc=0x100.
- fetch_pc=0x7FE (ADDR_W=11), free-running → addresses 0x7FE, 0x7FF, 0x000, 0x001 with matching instr_pc values.
- rst_n=0 for one cycle mid-stream with 2 entries queued and a read pending → instr_valid=0, occupancy=0, pending data dropped, next issue at RESET_PC.
